// File: rtl/alu_pkg.sv
// Shared EX-stage definitions: datapath width, ALU op encodings, forward select codes.
// No logic, so no latency; no flow control.
// No handshake of its own; the shift encodings are only meaningful when ALU_SHIFT_EN is defined.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    // The reserved select code falls back to the register-file value.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] w_val,
        input logic [XLEN-1:0] m_val
    );
        case (fwd_sel_e'(sel))
            FWD_W:   fwd_mux = w_val;
            FWD_M:   fwd_mux = m_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU core: add/sub/and/or/xor/slt, plus sll/srl when ALU_SHIFT_EN is defined.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing stage owns all holding and flushing.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic slt_bit;

    assign slt_bit = ($signed(SrcA) < $signed(SrcB));

    always_comb begin
        Result = '0;
        case (alu_op_e'(ALUControl))
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt_bit};
`ifdef ALU_SHIFT_EN
            ALU_SLL: Result = SrcA << SrcB[4:0];
            ALU_SRL: Result = SrcA >> SrcB[4:0];
`endif
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// EX stage: forwarding muxes, ALU, and the EX/MEM register (shifter enabled by ALU_SHIFT_EN).
// Latency: one cycle from EX inputs to M outputs; ZeroE is combinational.
// Backpressure: StallE holds the EX/MEM register; FlushE (wins over StallE) inserts a bubble.
module ex_alu_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidE,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [2:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic            ValidM,
    output logic            ZeroE
);

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [XLEN-1:0] write_data_d, write_data_q;
    logic [4:0]      rd_d, rd_q;
    logic            valid_d, valid_q;

    // The M-stage forward source is this stage's own register, so a dependent op issues back-to-back.
    assign src_a = fwd_mux(ForwardAE, RD1E, ResultW, alu_result_q);
    assign fwd_b = fwd_mux(ForwardBE, RD2E, ResultW, alu_result_q);
    assign src_b = ALUSrcE ? ImmExtE : fwd_b;

    alu u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (ZeroE)
    );

    always_comb begin
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        if (FlushE || (!StallE && !ValidE)) begin
            alu_result_d = '0;
            write_data_d = '0;
            rd_d         = '0;
            valid_d      = 1'b0;
        end else if (!StallE) begin
            alu_result_d = alu_result;
            write_data_d = fwd_b;
            rd_d         = RdE;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            valid_q      <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign ValidM     = valid_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage; shift expectations follow ALU_SHIFT_EN.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Backpressure cases: stall hold, flush over stall, bubble on ValidE=0, async reset mid-stall.
module tb_ex_alu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidE, StallE, FlushE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E, RD2E, ImmExtE, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;
    logic        ValidM, ZeroE;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_alu_stage dut (
        .clk         (clk),
        .reset       (reset),
        .ValidE      (ValidE),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .RdE         (RdE),
        .ResultW     (ResultW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .ValidM      (ValidM),
        .ZeroE       (ZeroE)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ValidE = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        ALUControlE = op; ALUSrcE = 1'b0;
        RD1E = a; RD2E = b; RdE = rd;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(3'b000, 32'd1, 32'd1, 5'd1);
        step();
        step();
        total++; if (ALUResultM !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", ALUResultM); end
        total++; if (WriteDataM !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", WriteDataM); end
        total++; if (RdM !== 5'd0)         begin bad++; $display("FAIL reset_rd got=%0d exp=0", RdM); end
        total++; if (ValidM !== 1'b0)      begin bad++; $display("FAIL reset_valid got=%b exp=0", ValidM); end
        reset = 1'b0;
    endtask

    task automatic test_dependency();
        issue(3'b000, 32'd5, 32'd7, 5'd3);
        step();
        total++; if (ALUResultM !== 32'd12) begin bad++; $display("FAIL dep_add got=%h exp=c", ALUResultM); end
        total++; if (WriteDataM !== 32'd7)  begin bad++; $display("FAIL dep_add_wdata got=%h exp=7", WriteDataM); end
        total++; if (RdM !== 5'd3 || ValidM !== 1'b1) begin bad++; $display("FAIL dep_add_rdv got=%0d/%b exp=3/1", RdM, ValidM); end
        issue(3'b001, 32'hDEAD_BEEF, 32'd2, 5'd4);
        ForwardAE = 2'b10;
        step();
        total++; if (ALUResultM !== 32'd10) begin bad++; $display("FAIL dep_sub got=%h exp=a", ALUResultM); end
        total++; if (RdM !== 5'd4) begin bad++; $display("FAIL dep_sub_rd got=%0d exp=4", RdM); end
    endtask

    task automatic test_ops();
        logic [2:0]  ops [7];
        logic [31:0] as  [7];
        logic [31:0] bs  [7];
        logic [31:0] exp [7];
        ops[0] = 3'b101; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h1;         exp[0] = 32'h1;
        ops[1] = 3'b101; as[1] = 32'h1;         bs[1] = 32'hFFFF_FFFF; exp[1] = 32'h0;
        ops[2] = 3'b000; as[2] = 32'h7FFF_FFFF; bs[2] = 32'h1;         exp[2] = 32'h8000_0000;
        ops[3] = 3'b001; as[3] = 32'h0;         bs[3] = 32'h1;         exp[3] = 32'hFFFF_FFFF;
        ops[4] = 3'b010; as[4] = 32'hF0F0_00FF; bs[4] = 32'h0FF0_0F0F; exp[4] = 32'h00F0_000F;
        ops[5] = 3'b011; as[5] = 32'hF0F0_00FF; bs[5] = 32'h0FF0_0F0F; exp[5] = 32'hFFF0_0FFF;
        ops[6] = 3'b100; as[6] = 32'hF0F0_00FF; bs[6] = 32'h0FF0_0F0F; exp[6] = 32'hFF00_0FF0;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], 5'd9);
            step();
            total++;
            if (ALUResultM !== exp[i]) begin
                bad++; $display("FAIL op_vec%0d op=%b got=%h exp=%h", i, ops[i], ALUResultM, exp[i]);
            end
        end
    endtask

    task automatic test_imm_fwd();
        issue(3'b000, 32'd4, 32'h99, 5'd7);
        ALUSrcE = 1'b1; ImmExtE = 32'hFFFF_FFFC; ForwardBE = 2'b01; ResultW = 32'h55;
        #1;
        total++; if (ZeroE !== 1'b1) begin bad++; $display("FAIL imm_zero got=%b exp=1", ZeroE); end
        step();
        total++; if (ALUResultM !== 32'h0)  begin bad++; $display("FAIL imm_result got=%h exp=0", ALUResultM); end
        total++; if (WriteDataM !== 32'h55) begin bad++; $display("FAIL imm_wdata got=%h exp=55", WriteDataM); end
        issue(3'b000, 32'd5, 32'h99, 5'd7);
        ALUSrcE = 1'b1; ImmExtE = 32'hFFFF_FFFC;
        #1;
        total++; if (ZeroE !== 1'b0) begin bad++; $display("FAIL imm_nonzero got=%b exp=0", ZeroE); end
    endtask

    task automatic test_stall_flush();
        issue(3'b000, 32'd1, 32'd2, 5'd5);
        step();
        for (int i = 0; i < 3; i++) begin
            issue(3'b100, 32'h1234 + i, 32'h77, 5'd20 + 5'(i));
            StallE = 1'b1;
            ForwardAE = 2'b10;
            step();
            total++;
            if (ALUResultM !== 32'd3 || WriteDataM !== 32'd2 || RdM !== 5'd5 || ValidM !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%h/%0d/%b exp=3/2/5/1", i, ALUResultM, WriteDataM, RdM, ValidM);
            end
        end
        StallE = 1'b1; FlushE = 1'b1;
        step();
        total++;
        if (ValidM !== 1'b0 || RdM !== 5'd0 || ALUResultM !== 32'h0 || WriteDataM !== 32'h0) begin
            bad++; $display("FAIL flush_stall got=%h/%h/%0d/%b exp=0/0/0/0", ALUResultM, WriteDataM, RdM, ValidM);
        end
    endtask

    task automatic test_bubble();
        issue(3'b001, 32'd3, 32'd3, 5'd11);
        ValidE = 1'b0;
        #1;
        total++; if (ZeroE !== 1'b1) begin bad++; $display("FAIL bubble_zero got=%b exp=1", ZeroE); end
        RD2E = 32'd9;
        step();
        total++;
        if (ValidM !== 1'b0 || RdM !== 5'd0 || ALUResultM !== 32'h0 || WriteDataM !== 32'h0) begin
            bad++; $display("FAIL bubble got=%h/%h/%0d/%b exp=0/0/0/0", ALUResultM, WriteDataM, RdM, ValidM);
        end
    endtask

    task automatic test_async_reset();
        issue(3'b011, 32'h10, 32'h01, 5'd12);
        step();
        total++; if (ValidM !== 1'b1 || ALUResultM !== 32'h11) begin bad++; $display("FAIL pre_reset got=%h/%b exp=11/1", ALUResultM, ValidM); end
        StallE = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ALUResultM !== 32'h0 || WriteDataM !== 32'h0 || RdM !== 5'd0 || ValidM !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%h/%h/%0d/%b exp=0/0/0/0", ALUResultM, WriteDataM, RdM, ValidM);
        end
        #1;
        reset = 1'b0;
        step();
        total++; if (ValidM !== 1'b0 || ALUResultM !== 32'h0) begin bad++; $display("FAIL post_reset_stall got=%h/%b exp=0/0", ALUResultM, ValidM); end
        StallE = 1'b0;
        step();
        total++; if (ValidM !== 1'b1 || ALUResultM !== 32'h11 || RdM !== 5'd12) begin bad++; $display("FAIL post_reset_load got=%h/%0d/%b exp=11/12/1", ALUResultM, RdM, ValidM); end
    endtask

    task automatic test_shift();
        logic [31:0] exp_sll, exp_srl;
`ifdef ALU_SHIFT_EN
        exp_sll = 32'd16;
        exp_srl = 32'd1;
`else
        exp_sll = 32'd0;
        exp_srl = 32'd0;
`endif
        issue(3'b110, 32'd1, 32'd4, 5'd13);
        step();
        total++; if (ALUResultM !== exp_sll) begin bad++; $display("FAIL shift_110 got=%h exp=%h", ALUResultM, exp_sll); end
        issue(3'b111, 32'h8000_0000, 32'd31, 5'd14);
        step();
        total++; if (ALUResultM !== exp_srl) begin bad++; $display("FAIL shift_111 got=%h exp=%h", ALUResultM, exp_srl); end
        total++; if (ValidM !== 1'b1 || RdM !== 5'd14) begin bad++; $display("FAIL shift_rdv got=%0d/%b exp=14/1", RdM, ValidM); end
    endtask

    initial begin
        ImmExtE = '0;
        ResultW = '0;
        test_reset();
        test_dependency();
        test_ops();
        test_imm_fwd();
        test_stall_flush();
        test_bubble();
        test_async_reset();
        test_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
